// File: rtl/rptr_empty_fwft.sv
// ---------------------------------------------------------------------------
// rptr_empty_fwft
//
// Read-clock-domain half of a dual-clock asynchronous FIFO. Keeps the binary
// and Gray read pointers, works out the memory-empty flag against the
// synchronised Gray write pointer, and puts memory words on a valid/ready
// stream through a one-entry first-word-fall-through output register. It also
// reports how many words are still in memory and whether that count is at or
// below the almost-empty threshold.
//
// Ports
//   rclk           read clock; all state changes on its rising edge
//   rrst_n         asynchronous active-low reset
//   rq2_wptr       Gray write pointer, already synchronised into rclk
//   rdata_mem      memory read data for raddr (combinational read)
//   raddr          memory read address (low bits of the binary read pointer)
//   rptr           registered Gray read pointer for the write-side synchroniser
//   rempty         registered memory-empty flag (ignores the output register)
//   dout           output data word
//   dout_valid     dout holds a word
//   dout_ready     downstream takes dout this cycle
//   rlevel         registered count of words still in memory, 0..2^ASIZE
//   ralmost_empty  registered, high when rlevel <= AE_LEVEL
// ---------------------------------------------------------------------------
module rptr_empty_fwft #(
  parameter int ASIZE    = 4,
  parameter int DSIZE    = 8,
  parameter int AE_LEVEL = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [ASIZE:0]   rq2_wptr,
  input  logic [DSIZE-1:0] rdata_mem,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic [DSIZE-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [ASIZE:0]   rlevel,
  output logic             ralmost_empty
);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  localparam logic [ASIZE:0] AE_THRESH = (ASIZE+1)'(AE_LEVEL);

  out_state_e       out_state_q, out_state_d;
  logic [ASIZE:0]   rbin_q, rbin_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic             rempty_q, rempty_d;
  logic [DSIZE-1:0] dout_q, dout_d;
  logic [ASIZE:0]   rlevel_q, rlevel_d;
  logic             ralmost_empty_q, ralmost_empty_d;

  logic             rinc;
  logic [ASIZE:0]   wbin;
  logic [ASIZE:0]   level;

  // Pull a word whenever memory has one and the output register is free or
  // being drained this cycle; this is what removes the bubble on a drain.
  assign rinc = ~rempty_q & ((out_state_q == OUT_EMPTY) | dout_ready);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    rbin_d          = rbin_q + {{ASIZE{1'b0}}, rinc};
    rptr_d          = (rbin_d >> 1) ^ rbin_d;
    rempty_d        = (rptr_d == rq2_wptr);
    out_state_d     = out_state_q;
    dout_d          = dout_q;

    // Gray to binary: each bit is the XOR of itself and every bit above it.
    wbin[ASIZE] = rq2_wptr[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ rq2_wptr[i];
    end

    // Modulo subtraction keeps the count right across pointer wrap, since
    // the write pointer is never more than 2^ASIZE ahead.
    level           = wbin - rbin_d;
    rlevel_d        = level;
    ralmost_empty_d = (level <= AE_THRESH);

    case (out_state_q)
      OUT_EMPTY: begin
        if (rinc) begin
          dout_d      = rdata_mem;
          out_state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (dout_ready) begin
          if (rinc) begin
            dout_d = rdata_mem;
          end else begin
            // Word consumed with nothing to replace it; dout keeps the stale
            // value but is no longer flagged valid.
            out_state_d = OUT_EMPTY;
          end
        end
      end
      default: out_state_d = OUT_EMPTY;
    endcase
  end

  // NOTE: reset is asynchronous so a word sitting in dout is dropped at once,
  // without needing a read clock edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      out_state_q     <= OUT_EMPTY;
      rbin_q          <= '0;
      rptr_q          <= '0;
      rempty_q        <= 1'b1;
      dout_q          <= '0;
      rlevel_q        <= '0;
      ralmost_empty_q <= 1'b1;
    end else begin
      out_state_q     <= out_state_d;
      rbin_q          <= rbin_d;
      rptr_q          <= rptr_d;
      rempty_q        <= rempty_d;
      dout_q          <= dout_d;
      rlevel_q        <= rlevel_d;
      ralmost_empty_q <= ralmost_empty_d;
    end
  end

  assign raddr         = rbin_q[ASIZE-1:0];
  assign rptr          = rptr_q;
  assign rempty        = rempty_q;
  assign dout          = dout_q;
  assign dout_valid    = (out_state_q == OUT_FULL);
  assign rlevel        = rlevel_q;
  assign ralmost_empty = ralmost_empty_q;

endmodule
